mic_volume_meter: RTL and testbench

- Upstream feeder for the game/menu controller: converts raw 12-bit microphone samples into the 5-bit `volume` level used by the volume screen, the record stage and gameplay.
- Measures the peak deviation of each sample from mid-scale over a fixed window of samples and quantises that peak to a level from 0 to MAX_LEVEL.
- Level rises instantly (fast attack) and falls by 1 per window (slow release), so the on-screen meter does not flicker.

---
 rtl/mic_volume_meter.sv | 102 ++++++++++
 tb/tb_mic_volume_meter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mic_volume_meter.sv
// mic_volume_meter: turns raw 12-bit microphone samples into a smoothed
// 0..MAX_LEVEL volume level. Each window of WINDOW_SAMPLES valid samples
// tracks the peak deviation from mid-scale. At the end of the window that
// peak is quantised to a level. The level rises at once and falls by one
// step per window.
module mic_volume_meter #(
   parameter int WINDOW_SAMPLES = 4000,
   parameter int MID_SCALE      = 2048,
   parameter int NOISE_FLOOR    = 64,
   parameter int LEVEL_SHIFT    = 7,
   parameter int MAX_LEVEL      = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sample_valid,
   input  logic [11:0] mic_in,
   output logic [4:0]  volume,
   output logic [10:0] peak,
   output logic        window_done
);

   localparam logic [11:0] MID   = 12'(MID_SCALE);
   localparam logic [15:0] LAST  = 16'(WINDOW_SAMPLES - 1);
   localparam logic [10:0] FLOOR = 11'(NOISE_FLOOR);
   localparam logic [11:0] MAXL  = 12'(MAX_LEVEL);

   logic [10:0] run_peak_q, run_peak_d;
   logic [15:0] cnt_q, cnt_d;
   logic [4:0]  volume_q, volume_d;
   logic [10:0] peak_q, peak_d;
   logic        done_q, done_d;

   logic [11:0] diff;
   logic [10:0] mag;
   logic [10:0] final_pk;
   logic [10:0] above;
   logic [10:0] shifted;
   logic [11:0] lvl_raw;
   logic [4:0]  new_level;
   logic        close;

   // Per-sample magnitude, saturated to 11 bits, and the level that the window would produce if it closed now.
   always_comb begin
      diff     = (mic_in >= MID) ? (mic_in - MID) : (MID - mic_in);
      mag      = diff[11] ? 11'h7FF : diff[10:0];
      final_pk = (mag > run_peak_q) ? mag : run_peak_q;
      above    = final_pk - FLOOR;
      shifted  = above >> LEVEL_SHIFT;
      lvl_raw  = {1'b0, shifted} + 12'd1;
      if (final_pk < FLOOR)
         new_level = 5'd0;
      else if (lvl_raw > MAXL)
         new_level = MAXL[4:0];
      else
         new_level = lvl_raw[4:0];
      close = sample_valid && (cnt_q == LAST);
   end

   // Next-state: accumulate the running peak, then at window close publish the peak and apply attack/release.
   always_comb begin
      run_peak_d = run_peak_q;
      cnt_d      = cnt_q;
      volume_d   = volume_q;
      peak_d     = peak_q;
      done_d     = 1'b0;
      if (close) begin
         run_peak_d = 11'd0;
         cnt_d      = 16'd0;
         peak_d     = final_pk;
         done_d     = 1'b1;
         if (new_level >= volume_q)
            volume_d = new_level;
         else
            volume_d = volume_q - 5'd1;
      end else if (sample_valid) begin
         run_peak_d = final_pk;
         cnt_d      = cnt_q + 16'd1;
      end
   end

   // State registers; reset wins over any sample in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         run_peak_q <= 11'd0;
         cnt_q      <= 16'd0;
         volume_q   <= 5'd0;
         peak_q     <= 11'd0;
         done_q     <= 1'b0;
      end else begin
         run_peak_q <= run_peak_d;
         cnt_q      <= cnt_d;
         volume_q   <= volume_d;
         peak_q     <= peak_d;
         done_q     <= done_d;
      end
   end

   assign volume      = volume_q;
   assign peak        = peak_q;
   assign window_done = done_q;

endmodule

// File: tb/tb_mic_volume_meter.sv
// Bench for mic_volume_meter with an 8-sample window. A reference model
// keeps the samples of the current window in a queue. When the window
// closes, the model derives peak and level from that queue.
module tb_mic_volume_meter;

   localparam int W = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        sample_valid = 1'b0;
   logic [11:0] mic_in = 12'd2048;
   logic [4:0]  volume;
   logic [10:0] peak;
   logic        window_done;

   int n_cmp = 0;
   int n_err = 0;

   int m_vol  = 0;
   int m_peak = 0;
   int m_done = 0;
   int win_q[$];

   mic_volume_meter #(.WINDOW_SAMPLES(W)) dut (
      .clk(clk), .rst(rst), .sample_valid(sample_valid), .mic_in(mic_in),
      .volume(volume), .peak(peak), .window_done(window_done)
   );

   always #5 clk = ~clk;

   function automatic int mag_of(input int m);
      int d;
      d = (m > 2048) ? m - 2048 : 2048 - m;
      return (d > 2047) ? 2047 : d;
   endfunction

   function automatic int level_of(input int f);
      int l;
      if (f < 64) return 0;
      l = ((f - 64) >> 7) + 1;
      return (l > 16) ? 16 : l;
   endfunction

   // Apply one cycle of input at a falling edge. Update the model, then
   // return at the next falling edge, when the DUT outputs are settled.
   task automatic step(input logic v, input int m);
      int mx;
      int nl;
      sample_valid = v;
      mic_in       = 12'(m);
      m_done       = 0;
      if (v) begin
         win_q.push_back(mag_of(m));
         if (win_q.size() == W) begin
            mx = 0;
            foreach (win_q[i]) if (win_q[i] > mx) mx = win_q[i];
            m_peak = mx;
            nl = level_of(mx);
            m_vol = (nl >= m_vol) ? nl : ((m_vol > 0) ? m_vol - 1 : 0);
            m_done = 1;
            win_q.delete();
         end
      end
      @(negedge clk);
      sample_valid = 1'b0;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      sample_valid = 1'b0;
      repeat (n) @(negedge clk);
      rst = 1'b0;
      m_vol = 0; m_peak = 0; m_done = 0;
      win_q.delete();
   endtask

   task automatic test_reset();
      do_reset(2);
      n_cmp++; if (volume !== 5'd0) begin n_err++; $display("FAIL reset_volume: got %0d want 0", volume); end
      n_cmp++; if (peak !== 11'd0) begin n_err++; $display("FAIL reset_peak: got %0d want 0", peak); end
      n_cmp++; if (window_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %0b want 0", window_done); end
   endtask

   task automatic test_silence();
      int pulses = 0;
      for (int i = 0; i < W; i++) begin
         step(1'b1, 2048);
         if (window_done) pulses++;
         n_cmp++; if (window_done !== 1'(m_done)) begin n_err++; $display("FAIL silence_done[%0d]: got %0b want %0d", i, window_done, m_done); end
      end
      n_cmp++; if (pulses != 1) begin n_err++; $display("FAIL silence_pulses: got %0d want 1", pulses); end
      n_cmp++; if (volume !== 5'd0 || peak !== 11'd0) begin n_err++; $display("FAIL silence_out: got vol %0d peak %0d want 0 0", volume, peak); end
   endtask

   task automatic test_attack();
      for (int i = 0; i < W - 1; i++) step(1'b1, 2048);
      step(1'b1, 0);
      n_cmp++; if (window_done !== 1'b1) begin n_err++; $display("FAIL attack_done: got %0b want 1", window_done); end
      n_cmp++; if (peak !== 11'd2047) begin n_err++; $display("FAIL attack_peak: got %0d want 2047", peak); end
      n_cmp++; if (volume !== 5'd16) begin n_err++; $display("FAIL attack_volume: got %0d want 16", volume); end
      step(1'b0, 0);
      n_cmp++; if (window_done !== 1'b0 || volume !== 5'd16) begin n_err++; $display("FAIL attack_hold: got done %0b vol %0d want 0 16", window_done, volume); end
   endtask

   task automatic test_release();
      for (int w = 0; w < 3; w++) begin
         for (int i = 0; i < W; i++) step(1'b1, 2048);
         n_cmp++; if (window_done !== 1'b1) begin n_err++; $display("FAIL release_done[%0d]: got %0b want 1", w, window_done); end
         n_cmp++; if (volume !== 5'(15 - w)) begin n_err++; $display("FAIL release_volume[%0d]: got %0d want %0d", w, volume, 15 - w); end
         n_cmp++; if (peak !== 11'd0) begin n_err++; $display("FAIL release_peak[%0d]: got %0d want 0", w, peak); end
      end
   endtask

   task automatic test_thresholds();
      int mags[3] = '{63, 64, 200};
      do_reset(1);
      for (int w = 0; w < 3; w++) begin
         for (int i = 0; i < W; i++) step(1'b1, (i == 3) ? 2048 + mags[w] : 2048);
         n_cmp++; if (volume !== 5'(w)) begin n_err++; $display("FAIL thresh_volume[mag %0d]: got %0d want %0d", mags[w], volume, w); end
         n_cmp++; if (peak !== 11'(mags[w])) begin n_err++; $display("FAIL thresh_peak[mag %0d]: got %0d want %0d", mags[w], peak, mags[w]); end
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 5; i++) step(1'b1, 3048);
      do_reset(1);
      for (int i = 0; i < W; i++) begin
         step(1'b1, 2048);
         n_cmp++; if (window_done !== ((i == W - 1) ? 1'b1 : 1'b0)) begin n_err++; $display("FAIL rstmid_done[%0d]: got %0b want %0b", i, window_done, (i == W - 1)); end
      end
      n_cmp++; if (volume !== 5'd0 || peak !== 11'd0) begin n_err++; $display("FAIL rstmid_out: got vol %0d peak %0d want 0 0", volume, peak); end
   endtask

   task automatic test_back_to_back();
      int pulse_cyc[$];
      do_reset(1);
      for (int i = 0; i < 3 * W; i++) begin
         step(1'b1, 2048 + 80 * i);
         if (window_done) begin
            pulse_cyc.push_back(i);
            n_cmp++; if (peak !== 11'(80 * i)) begin n_err++; $display("FAIL b2b_peak[%0d]: got %0d want %0d", i, peak, 80 * i); end
            n_cmp++; if (volume !== 5'(m_vol)) begin n_err++; $display("FAIL b2b_volume[%0d]: got %0d want %0d", i, volume, m_vol); end
         end
      end
      n_cmp++; if (pulse_cyc.size() != 3) begin n_err++; $display("FAIL b2b_pulses: got %0d want 3", pulse_cyc.size()); end
      else begin
         n_cmp++; if (pulse_cyc[1] - pulse_cyc[0] != W || pulse_cyc[2] - pulse_cyc[1] != W) begin n_err++; $display("FAIL b2b_spacing: got %0d,%0d want %0d", pulse_cyc[1] - pulse_cyc[0], pulse_cyc[2] - pulse_cyc[1], W); end
      end
   endtask

   task automatic test_random();
      int amp;
      int m;
      do_reset(1);
      for (int i = 0; i < 600; i++) begin
         if (i % 40 == 0) amp = (i % 120 == 0) ? 2100 : $urandom_range(0, 600);
         m = 2048 + $urandom_range(0, amp) - amp / 2;
         if (m < 0) m = 0;
         if (m > 4095) m = 4095;
         step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, m);
         n_cmp++; if (window_done !== 1'(m_done)) begin n_err++; $display("FAIL rand_done[%0d]: got %0b want %0d", i, window_done, m_done); end
         n_cmp++; if (volume !== 5'(m_vol)) begin n_err++; $display("FAIL rand_volume[%0d]: got %0d want %0d", i, volume, m_vol); end
         n_cmp++; if (peak !== 11'(m_peak)) begin n_err++; $display("FAIL rand_peak[%0d]: got %0d want %0d", i, peak, m_peak); end
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_silence();
      test_attack();
      test_release();
      test_thresholds();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
